// File: rtl/dffram_wb_pkg.sv
// Shared types and constants for the Wishbone front end of the DFFRAM macro.
// The ERR state exists only when WB_RAM_ERR_EN is defined.
package dffram_wb_pkg;

  localparam int DATA_W = 32;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
`ifdef WB_RAM_ERR_EN
    ACK     = 2'd2,
    ERR     = 2'd3
`else
    ACK     = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/dffram_wb_ctrl_if.sv
// Wishbone B4 classic slave-side bus bundle for dffram_wb_ctrl.
import dffram_wb_pkg::*;

interface dffram_wb_ctrl_if;
  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [LANES-1:0]  wbs_sel_i;
  logic [31:0]       wbs_adr_i;
  logic [DATA_W-1:0] wbs_dat_i;
  logic              wbs_ack_o;
  logic              wbs_err_o;
  logic [DATA_W-1:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_err_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_err_o, wbs_dat_o
  );
endinterface

// File: rtl/dffram_wb_ctrl.sv
// Wishbone slave driving the single-port DFFRAM strobes; one access in flight.
// Define WB_RAM_ERR_EN to answer out-of-window addresses with an err pulse.
import dffram_wb_pkg::*;

module dffram_wb_ctrl #(
  parameter int          AW        = 9,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  dffram_wb_ctrl_if.slave   wb,
  output logic              ram_en0,
  output logic [LANES-1:0]  ram_we0,
  output logic [AW-1:0]     ram_a0,
  output logic [DATA_W-1:0] ram_di0,
  input  logic [DATA_W-1:0] ram_do0
);

  state_t             r_state;
  state_t             w_next;
  logic [DATA_W-1:0]  r_dat;
  logic               w_req;
  logic               w_hit;
  logic               w_en;
  logic [LANES-1:0]   w_we;
  logic               w_unused;

  assign w_req = wb.wbs_cyc_i & wb.wbs_stb_i;

`ifdef WB_RAM_ERR_EN
  assign w_hit    = (wb.wbs_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign w_unused = &{1'b0, wb.wbs_adr_i[1:0]};
`else
  assign w_hit    = 1'b1;
  assign w_unused = &{1'b0, wb.wbs_adr_i[1:0], wb.wbs_adr_i[31:AW+2], BASE_ADDR};
`endif

  // RAM strobes are only ever issued from IDLE; every other state is quiet.
  always_comb begin
    w_next = r_state;
    w_en   = 1'b0;
    w_we   = '0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
`ifdef WB_RAM_ERR_EN
          if (!w_hit)
            w_next = ERR;
          else
`endif
          if (wb.wbs_we_i) begin
            w_en   = |wb.wbs_sel_i;
            w_we   = wb.wbs_sel_i;
            w_next = ACK;
          end else begin
            w_en   = 1'b1;
            w_next = RD_WAIT;
          end
        end
      end
      RD_WAIT: w_next = wb.wbs_cyc_i ? ACK : IDLE;
      ACK:     w_next = IDLE;
`ifdef WB_RAM_ERR_EN
      ERR:     w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end

  assign ram_en0 = w_en & ~RST & w_hit;
  assign ram_we0 = RST ? '0 : w_we;
  assign ram_a0  = wb.wbs_adr_i[AW+1:2];
  assign ram_di0 = wb.wbs_dat_i;

  // Read data is captured only if the master is still in the cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_dat   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == RD_WAIT && wb.wbs_cyc_i)
        r_dat <= ram_do0;
    end
  end

  assign wb.wbs_ack_o = (r_state == ACK);
  assign wb.wbs_dat_o = r_dat;
`ifdef WB_RAM_ERR_EN
  assign wb.wbs_err_o = (r_state == ERR);
`else
  assign wb.wbs_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dffram_wb_ctrl.sv
// Directed bench for dffram_wb_ctrl with a behavioural 512x32 byte-lane RAM.
`timescale 1ns/1ps
import dffram_wb_pkg::*;

module tb_dffram_wb_ctrl;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk;
  logic        rst;
  logic        ramEn;
  logic [3:0]  ramWe;
  logic [8:0]  ramA;
  logic [31:0] ramDi;
  logic [31:0] ramDo;
  logic [31:0] mem [0:511];
  int          checks;
  int          errors;

  dffram_wb_ctrl_if busIf ();

  dffram_wb_ctrl #(.AW(9), .BASE_ADDR(BASE)) dut (
    .CLK     (clk),
    .RST     (rst),
    .wb      (busIf.slave),
    .ram_en0 (ramEn),
    .ram_we0 (ramWe),
    .ram_a0  (ramA),
    .ram_di0 (ramDi),
    .ram_do0 (ramDo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural DFFRAM: byte-lane writes, read data one edge after enable.
  always @(posedge clk) begin
    if (ramEn) begin
      for (int b = 0; b < 4; b++)
        if (ramWe[b]) mem[ramA][8*b +: 8] <= ramDi[8*b +: 8];
      if (ramWe == 4'b0000) ramDo <= mem[ramA];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] adr,
                               input logic [31:0] dat, input logic [3:0] sel);
    @(negedge clk);
    busIf.wbs_cyc_i = 1'b1;
    busIf.wbs_stb_i = 1'b1;
    busIf.wbs_we_i  = we;
    busIf.wbs_adr_i = adr;
    busIf.wbs_dat_i = dat;
    busIf.wbs_sel_i = sel;
  endtask

  task automatic releaseBus();
    busIf.wbs_cyc_i = 1'b0;
    busIf.wbs_stb_i = 1'b0;
    busIf.wbs_we_i  = 1'b0;
  endtask

  task automatic wbWrite(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic expEn, input logic [8:0] expA);
    applyStimulus(1'b1, adr, dat, sel);
    #1;
    checkOutput("wr_en0", ramEn, expEn);
    checkOutput("wr_we0", ramWe, sel);
    checkOutput("wr_a0", ramA, expA);
    checkOutput("wr_di0", ramDi, dat);
    @(negedge clk);
    checkOutput("wr_ack", busIf.wbs_ack_o, 1'b1);
    checkOutput("wr_err", busIf.wbs_err_o, 1'b0);
    checkOutput("wr_ack_en0", ramEn, 1'b0);
    releaseBus();
    @(negedge clk);
    checkOutput("wr_ack_pulse", busIf.wbs_ack_o, 1'b0);
  endtask

  task automatic wbRead(input logic [31:0] adr, input logic [8:0] expA, input logic [31:0] expDat);
    applyStimulus(1'b0, adr, 32'h0, 4'hF);
    #1;
    checkOutput("rd_en0", ramEn, 1'b1);
    checkOutput("rd_we0", ramWe, 4'h0);
    checkOutput("rd_a0", ramA, expA);
    @(negedge clk);
    checkOutput("rd_wait_ack", busIf.wbs_ack_o, 1'b0);
    checkOutput("rd_wait_en0", ramEn, 1'b0);
    @(negedge clk);
    checkOutput("rd_ack", busIf.wbs_ack_o, 1'b1);
    checkOutput("rd_dat", busIf.wbs_dat_o, expDat);
    releaseBus();
    @(negedge clk);
    checkOutput("rd_ack_pulse", busIf.wbs_ack_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    ramDo  = 32'h0;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    rst = 1'b1;
    busIf.wbs_cyc_i = 1'b1;
    busIf.wbs_stb_i = 1'b1;
    busIf.wbs_we_i  = 1'b1;
    busIf.wbs_sel_i = 4'hF;
    busIf.wbs_adr_i = BASE;
    busIf.wbs_dat_i = 32'hFFFF_FFFF;

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("rst_ack", busIf.wbs_ack_o, 1'b0);
      checkOutput("rst_err", busIf.wbs_err_o, 1'b0);
      checkOutput("rst_dat", busIf.wbs_dat_o, 32'h0);
      checkOutput("rst_en0", ramEn, 1'b0);
      checkOutput("rst_we0", ramWe, 4'h0);
    end
    releaseBus();
    rst = 1'b0;
    @(negedge clk);

    wbWrite(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 9'd4);
    wbRead(BASE + 32'h10, 9'd4, 32'hDEAD_BEEF);

    wbWrite(BASE + 32'h7FC, 32'h1122_3344, 4'hF, 1'b1, 9'd511);
    wbWrite(BASE + 32'h7FC, 32'hAABB_CCDD, 4'b0101, 1'b1, 9'd511);
    checkOutput("dat_hold", busIf.wbs_dat_o, 32'hDEAD_BEEF);
    wbRead(BASE + 32'h7FC, 9'd511, 32'h11BB_33DD);

    wbWrite(BASE + 32'h20, 32'h55AA_55AA, 4'hF, 1'b1, 9'd8);
    applyStimulus(1'b0, BASE + 32'h20, 32'h0, 4'hF);
    #1;
    checkOutput("abort_en0", ramEn, 1'b1);
    @(negedge clk);
    releaseBus();
    @(negedge clk);
    checkOutput("abort_ack", busIf.wbs_ack_o, 1'b0);
    checkOutput("abort_dat", busIf.wbs_dat_o, 32'h11BB_33DD);
    @(negedge clk);
    checkOutput("abort_ack2", busIf.wbs_ack_o, 1'b0);
    wbRead(BASE + 32'h20, 9'd8, 32'h55AA_55AA);

`ifdef WB_RAM_ERR_EN
    applyStimulus(1'b1, BASE + 32'h800, 32'h1234_5678, 4'hF);
    #1;
    checkOutput("oow_en0", ramEn, 1'b0);
    @(negedge clk);
    checkOutput("oow_err", busIf.wbs_err_o, 1'b1);
    checkOutput("oow_ack", busIf.wbs_ack_o, 1'b0);
    checkOutput("oow_err_en0", ramEn, 1'b0);
    releaseBus();
    @(negedge clk);
    checkOutput("oow_err_pulse", busIf.wbs_err_o, 1'b0);
    wbRead(BASE, 9'd0, 32'h0);
`else
    wbWrite(BASE + 32'h800, 32'h1234_5678, 4'hF, 1'b1, 9'd0);
    wbRead(BASE, 9'd0, 32'h1234_5678);
`endif

    wbWrite(BASE, 32'hCAFE_F00D, 4'hF, 1'b1, 9'd0);
    wbWrite(BASE, 32'h0BAD_0BAD, 4'h0, 1'b0, 9'd0);
    wbRead(BASE, 9'd0, 32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dffram_wb_ctrl.md
# dffram_wb_ctrl

Wishbone B4 classic slave that fronts the 512x32 latch-based DFFRAM macro. Sits directly upstream of the RAM: it decodes bus cycles into the RAM's single-port EN0/WE0/A0/Di0 strobes, captures Do0, and returns registered ack/err responses. One access is in flight at a time; writes complete in one wait-free response cycle, reads in two.

## Interface
- AW, 9: RAM word-address width; RAM depth is 2^AW words.
- BASE_ADDR, 32'h3000_0000: byte base address of the RAM window; must be aligned to 2^(AW+2).
- CLK  in  1  system clock; RAM shares it.
- RST  in  1  reset, asynchronous, active-high.
- wbs_cyc_i  in  1  bus cycle valid.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte lane selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  one-cycle completion pulse.
- wbs_err_o  out  1  one-cycle error pulse; tied 0 unless WB_RAM_ERR_EN.
- wbs_dat_o  out  32  read data, registered.
- ram_en0  out  1  RAM enable.
- ram_we0  out  4  RAM byte write enables.
- ram_a0  out  AW  RAM word address = wbs_adr_i[AW+1:2].
- ram_di0  out  32  RAM write data = wbs_dat_i.
- ram_do0  in  32  RAM read data, valid the cycle after a read-enable edge.

## Operation
- States: IDLE, RD_WAIT, ACK, ERR (ERR only with WB_RAM_ERR_EN).
- Request = cyc & stb, sampled in IDLE only.
- IDLE, write request: ram_en0=1, ram_we0=wbs_sel_i for this cycle (combinational from bus); -> ACK.
- IDLE, write with sel=4'b0000: ram_en0=0, no RAM change; still -> ACK.
- IDLE, read request: ram_en0=1, ram_we0=0; -> RD_WAIT.
- RD_WAIT: ram_en0=0; capture ram_do0 into wbs_dat_o at the closing edge; -> ACK. If cyc drops in RD_WAIT: -> IDLE, no ack, wbs_dat_o unchanged.
- ACK: wbs_ack_o=1 for exactly this cycle; bus ignored; -> IDLE.
- ERR: wbs_err_o=1 for exactly this cycle; -> IDLE.
- ram_en0/ram_we0 are forced 0 whenever RST is high and in every state except IDLE.
- wbs_adr_i[1:0] ignored; no misalignment check.
- wbs_dat_o holds last read value across writes and idle cycles.

## Timing
- Reset values: state IDLE, wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0; ram_en0=0, ram_we0=0 while RST high.
- RST asserted mid-access: immediate return to IDLE, pending ack/err dropped; a write strobed in the same cycle is not guaranteed.
- Write: request at cycle 0 -> RAM written at edge ending cycle 0 -> ack in cycle 1.
- Read: request at cycle 0 -> RAM read edge ending cycle 0 -> data captured end of cycle 1 -> ack and valid wbs_dat_o in cycle 2.
- Back-to-back: next request accepted in the cycle after ACK; minimum 2 cycles/write, 3 cycles/read.
- Request held high through ACK is not re-accepted until the state returns to IDLE.

## Configuration
- WB_RAM_ERR_EN defined: request with wbs_adr_i[31:AW+2] != BASE_ADDR[31:AW+2] performs no RAM access (ram_en0=0) and goes IDLE -> ERR; err pulse in cycle 1, no ack.
- WB_RAM_ERR_EN undefined: upper address bits ignored, every address aliases into the RAM, wbs_err_o tied 0, ERR state absent.

## Structure
- Shared package dffram_wb_pkg: state enum (IDLE, RD_WAIT, ACK, ERR), RAM data width constant 32, byte-lane count 4.
- No sub-module; decode, FSM and response registers fit one module.

## Test plan
- Reset: RST high 3 cycles with cyc/stb high -> ack=0, err=0, dat_o=0, ram_en0=0 throughout.
- Full write then read: write 32'hDEADBEEF to BASE+0x10, sel=4'hF -> ack cycle 1, ram_a0=4; read same -> ack cycle 2, dat_o=32'hDEADBEEF.
- Byte lanes: write 32'h11223344 sel=4'hF, then 32'hAABBCCDD sel=4'b0101 to BASE+0x7FC -> read returns 32'h11BB33DD, ram_a0=511.
- Abort: read at BASE+0x20, drop cyc in RD_WAIT -> no ack, dat_o keeps previous value, next request accepted normally.
- Out-of-window BASE+0x800 with WB_RAM_ERR_EN: err in cycle 1, ram_en0 never high; without macro: aliases to word 0, ack in cycle 1.
- Sel zero: write sel=4'h0 to BASE+0x0 after writing 32'hCAFEF00D -> ack in cycle 1, ram_en0=0, readback 32'hCAFEF00D.
